op_accumulator: RTL and testbench
=================================

# op_accumulator

Parametrised multi-channel accumulator with add/subtract/load/read operations, wrap or saturate arithmetic, and valid/ready handshakes on both sides. It generalises our single add/sub counter to N independent channels of configurable width, with overflow reporting and backpressure. It sits between a command source and a downstream consumer and returns each updated channel value one cycle after acceptance.

## Interface
- `WIDTH`, 8: accumulator and data width in bits (≥2).
- `CHANNELS`, 4: number of independent accumulators (≥1; need not be a power of two).
- `SATURATE`, 0: 0 means wrap on overflow; 1 means clamp.
- `CW` (localparam): channel-index width, `$clog2(CHANNELS)`, minimum 1.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: command valid.
- `in_ready` output, 1 bit: command accepted when `in_valid && in_ready`.
- `in_op` input, 2 bits: 0 ADD, 1 SUB, 2 LOAD, 3 READ.
- `in_ch` input, CW bits: target channel.
- `in_data` input, WIDTH bits: unsigned operand.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_ch` output, CW bits: channel of the result.
- `out_data` output, WIDTH bits: channel value after the operation.
- `out_ovf` output, 1 bit: this operation overflowed or underflowed.
- `ovf_sticky` output, CHANNELS bits: per-channel sticky overflow flags.

## Operation
- State: `acc[CHANNELS]`, `ovf_sticky`, and a one-entry output register (`out_valid`, `out_ch`, `out_data`, `out_ovf`).
- `in_ready = !out_valid || out_ready`. This is combinational and gives full throughput of one command per cycle.
- On acceptance, `acc[in_ch]`, the output register, and `ovf_sticky` update at the same edge:
  - **ADD:** `acc + in_data`, unsigned. On carry, the result wraps (mod 2^WIDTH) or, with `SATURATE`, becomes all-ones. `out_ovf` is 1.
  - **SUB:** `acc − in_data`. On borrow, the result wraps or, with `SATURATE`, becomes 0. `out_ovf` is 1.
  - **LOAD:** `acc = in_data`. Clears `ovf_sticky[in_ch]`. `out_ovf` is 0.
  - **READ:** no change to `acc`. `out_data = acc[in_ch]`. `out_ovf` is 0.
  - Any overflow or underflow sets `ovf_sticky[in_ch]`. The flag stays set until a LOAD to that channel or a reset.
- **Out-of-range channel** (`in_ch ≥ CHANNELS`): the command is accepted, no state changes, and the response is `out_data=0`, `out_ovf=1`.
- **Backpressure:** while `out_valid && !out_ready`, all `out_*` outputs hold stable and `in_ready=0`.
- **Back-to-back commands to the same channel:** the second command operates on the value produced by the first. There is no hazard window.
- **Reset:** all `acc` = 0, `ovf_sticky` = 0, `out_valid` = 0, `out_ch` = 0, `out_data` = 0, `out_ovf` = 0. Any pending result is discarded. `rst` overrides any handshake in the same cycle.

## Timing
- Latency is 1 cycle: a command accepted at edge N produces a result visible with `out_valid=1` after edge N.
- `out_valid` clears after an edge where `out_ready=1` and no new command is accepted.
- **Simultaneous drain and accept** (`out_valid`, `out_ready`, and `in_valid` all 1): the old result is consumed and the new one is loaded at the same edge. `out_valid` stays 1.
- There are no combinational paths from `in_*` to `out_*`. The only combinational path is `out_ready` → `in_ready`.

## Structure
- Package `op_acc_pkg` holds:
  - the op encodings as a 2-bit typedef enum (`OP_ADD`, `OP_SUB`, `OP_LOAD`, `OP_READ`);
  - a helper function for the channel-index width.
- Sub-module `op_acc_alu` is purely combinational.
  - Inputs: `acc`, `in_data`, `op`, and the `SATURATE` parameter.
  - Outputs: result value and overflow flag.
- The top level holds the accumulator array, the sticky flags, the handshake, and the output register.

## Test plan
1. **Reset then READ:** with WIDTH=8, reset, then READ ch2. Expect one cycle later `out_data=0`, `out_ovf=0`, `out_ch=2`.
2. **Wrap mode:** LOAD ch1=250, then ADD ch1 10 with `SATURATE=0`. Expect `out_data=4`, `out_ovf=1`, `ovf_sticky[1]=1`. A following LOAD ch1=0 clears `ovf_sticky[1]`.
3. **Saturate mode:** with `SATURATE=1`, SUB 5 from ch0 (value 3). Expect `out_data=0`, `out_ovf=1`. ADD 255+1 gives 255, `out_ovf=1`.
4. **Backpressure:** hold `out_ready=0` for 3 cycles after a result. Expect `in_ready=0` and `out_*` stable. Then assert `out_ready` with `in_valid=1` and expect a new result the next cycle without a bubble.
5. **Back-to-back and out-of-range:** with CHANNELS=3, send ADD ch0 +1 four times back to back. Expect outputs 1, 2, 3, 4 on consecutive cycles. A command to ch3 returns `out_data=0`, `out_ovf=1` and leaves ch0–ch2 unchanged.
6. **Mid-stream reset:** assert `rst` while `out_valid=1` and `out_ready=0`. Expect `out_valid=0` next cycle and all channels reading 0.

Source files
------------

// File: rtl/op_acc_pkg.sv
// Shared definitions for the multi-channel op accumulator.
package op_acc_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_LOAD = 2'd2,
        OP_READ = 2'd3
    } op_e;

    // Channel-index width; a single channel still gets a 1-bit index.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/op_acc_alu.sv
// Combinational add/sub/load/read datapath with wrap or saturate on overflow.
module op_acc_alu
    import op_acc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] in_data,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, in_data};
        diff   = {1'b0, acc} - {1'b0, in_data};
        result = acc;
        ovf    = 1'b0;
        unique case (op)
            OP_ADD: begin
                ovf    = sum[WIDTH];
                result = (sum[WIDTH] && SATURATE != 0) ? '1 : sum[WIDTH-1:0];
            end
            OP_SUB: begin
                // The extra MSB of the difference is the borrow.
                ovf    = diff[WIDTH];
                result = (diff[WIDTH] && SATURATE != 0) ? '0 : diff[WIDTH-1:0];
            end
            OP_LOAD: result = in_data;
            OP_READ: result = acc;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/op_accumulator.sv
// N-channel accumulator with valid/ready command and result ports and a one-entry result register.
module op_accumulator
    import op_acc_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SATURATE = 0,
    localparam int unsigned CW      = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [CW-1:0]       in_ch,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CW-1:0]       out_ch,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_ovf,
    output logic [CHANNELS-1:0] ovf_sticky
);

    logic [WIDTH-1:0] acc [CHANNELS];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic             accept;
    logic             in_range;
    op_e              op;

    assign op       = op_e'(in_op);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_range = 32'(in_ch) < CHANNELS;

    // Explicit mux keeps out-of-range indices from reading past the array.
    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(in_ch) == i) cur = acc[i];
        end
    end

    op_acc_alu #(
        .WIDTH   (WIDTH),
        .SATURATE(SATURATE)
    ) u_alu (
        .acc    (cur),
        .in_data(in_data),
        .op     (op),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            out_ovf    <= 1'b0;
            ovf_sticky <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_ch    <= in_ch;
                out_data  <= in_range ? alu_result : '0;
                out_ovf   <= in_range ? alu_ovf : 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (accept && 32'(in_ch) == i) begin
                    if (op != OP_READ) acc[i] <= alu_result;
                    if (op == OP_LOAD)
                        ovf_sticky[i] <= 1'b0;
                    else if (alu_ovf)
                        ovf_sticky[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_op_accumulator.sv
// Directed bench: a wrap-mode 3-channel instance and a saturate-mode 4-channel instance share one command stream.
module tb_op_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [1:0] in_op;
    logic [1:0] in_ch;
    logic [7:0] in_data;

    logic       w_in_ready, w_out_valid, w_out_ovf;
    logic [1:0] w_out_ch;
    logic [7:0] w_out_data;
    logic [2:0] w_sticky;

    logic       s_in_ready, s_out_valid, s_out_ovf;
    logic [1:0] s_out_ch;
    logic [7:0] s_out_data;
    logic [3:0] s_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    op_accumulator #(.WIDTH(8), .CHANNELS(3), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_ch(in_ch), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_ch(w_out_ch),
        .out_data(w_out_data), .out_ovf(w_out_ovf), .ovf_sticky(w_sticky)
    );

    op_accumulator #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op(in_op), .in_ch(in_ch), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ch(s_out_ch),
        .out_data(s_out_data), .out_ovf(s_out_ovf), .ovf_sticky(s_sticky)
    );

    typedef struct {
        logic [1:0] op;
        logic [1:0] ch;
        logic [7:0] data;
        logic [7:0] w_data;
        logic       w_ovf;
        logic [2:0] w_st;
        logic [7:0] s_data;
        logic       s_ovf;
        logic [3:0] s_st;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LD = 2'd2, RD = 2'd3;

    function automatic void add_vec(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] data,
                                    input logic [7:0] w_data, input logic w_ovf, input logic [2:0] w_st,
                                    input logic [7:0] s_data, input logic s_ovf, input logic [3:0] s_st);
        vec_t v;
        v.op = op; v.ch = ch; v.data = data;
        v.w_data = w_data; v.w_ovf = w_ovf; v.w_st = w_st;
        v.s_data = s_data; v.s_ovf = s_ovf; v.s_st = s_st;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] ch, input logic [7:0] data);
        in_valid = v;
        in_op    = op;
        in_ch    = ch;
        in_data  = data;
    endtask

    task automatic check_both_out(input string tag, input logic vld, input logic [1:0] ch,
                                  input logic [7:0] wd, input logic wo, input logic [7:0] sd, input logic so);
        check({tag, " w_valid"}, 32'(w_out_valid), 32'(vld));
        check({tag, " w_ch"},    32'(w_out_ch),    32'(ch));
        check({tag, " w_data"},  32'(w_out_data),  32'(wd));
        check({tag, " w_ovf"},   32'(w_out_ovf),   32'(wo));
        check({tag, " s_valid"}, 32'(s_out_valid), 32'(vld));
        check({tag, " s_ch"},    32'(s_out_ch),    32'(ch));
        check({tag, " s_data"},  32'(s_out_data),  32'(sd));
        check({tag, " s_ovf"},   32'(s_out_ovf),   32'(so));
    endtask

    initial begin
        // op ch data | wrap: data ovf sticky | sat: data ovf sticky
        add_vec(RD,  2, 0,    0,   0, 3'b000,   0,   0, 4'b0000);
        add_vec(LD,  1, 250,  250, 0, 3'b000,   250, 0, 4'b0000);
        add_vec(ADD, 1, 10,   4,   1, 3'b010,   255, 1, 4'b0010);
        add_vec(LD,  1, 0,    0,   0, 3'b000,   0,   0, 4'b0000);
        add_vec(LD,  0, 3,    3,   0, 3'b000,   3,   0, 4'b0000);
        add_vec(SUB, 0, 5,    254, 1, 3'b001,   0,   1, 4'b0001);
        add_vec(LD,  0, 255,  255, 0, 3'b000,   255, 0, 4'b0000);
        add_vec(ADD, 0, 1,    0,   1, 3'b001,   255, 1, 4'b0001);
        add_vec(RD,  0, 0,    0,   0, 3'b001,   255, 0, 4'b0001);
        add_vec(LD,  0, 0,    0,   0, 3'b000,   0,   0, 4'b0000);
        add_vec(ADD, 0, 1,    1,   0, 3'b000,   1,   0, 4'b0000);
        add_vec(ADD, 0, 1,    2,   0, 3'b000,   2,   0, 4'b0000);
        add_vec(ADD, 0, 1,    3,   0, 3'b000,   3,   0, 4'b0000);
        add_vec(ADD, 0, 1,    4,   0, 3'b000,   4,   0, 4'b0000);
        add_vec(LD,  2, 7,    7,   0, 3'b000,   7,   0, 4'b0000);
        add_vec(ADD, 3, 9,    0,   1, 3'b000,   9,   0, 4'b0000);
        add_vec(RD,  0, 0,    4,   0, 3'b000,   4,   0, 4'b0000);
        add_vec(RD,  1, 0,    0,   0, 3'b000,   0,   0, 4'b0000);
        add_vec(RD,  2, 0,    7,   0, 3'b000,   7,   0, 4'b0000);
        add_vec(RD,  3, 0,    0,   1, 3'b000,   9,   0, 4'b0000);
        add_vec(SUB, 2, 7,    0,   0, 3'b000,   0,   0, 4'b0000);
        add_vec(ADD, 1, 255,  255, 0, 3'b000,   255, 0, 4'b0000);

        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, RD, 2'd0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_both_out("reset", 1'b0, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        check("reset w_sticky", 32'(w_sticky), 32'd0);
        check("reset s_sticky", 32'(s_sticky), 32'd0);
        check("reset w_in_ready", 32'(w_in_ready), 32'd1);

        // Table: one command per cycle with the consumer always ready.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].ch, vecs[i].data);
            check($sformatf("v%0d w_in_ready", i), 32'(w_in_ready), 32'd1);
            @(posedge clk); #1;
            check_both_out($sformatf("v%0d", i), 1'b1, vecs[i].ch,
                           vecs[i].w_data, vecs[i].w_ovf, vecs[i].s_data, vecs[i].s_ovf);
            check($sformatf("v%0d w_sticky", i), 32'(w_sticky), 32'(vecs[i].w_st));
            check($sformatf("v%0d s_sticky", i), 32'(s_sticky), 32'(vecs[i].s_st));
            @(negedge clk);
        end
        drive(1'b0, RD, 2'd0, 8'd0);
        @(posedge clk); #1;
        check("drain w_valid", 32'(w_out_valid), 32'd0);
        check("drain s_valid", 32'(s_out_valid), 32'd0);

        // Backpressure: result held, in_ready low, then drain+accept without a bubble.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, LD, 2'd0, 8'd42);
        @(posedge clk); #1;
        check_both_out("bp load", 1'b1, 2'd0, 8'd42, 1'b0, 8'd42, 1'b0);
        @(negedge clk);
        drive(1'b1, ADD, 2'd0, 8'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d w_in_ready", k), 32'(w_in_ready), 32'd0);
            check($sformatf("bp%0d s_in_ready", k), 32'(s_in_ready), 32'd0);
            @(posedge clk); #1;
            check_both_out($sformatf("bp%0d hold", k), 1'b1, 2'd0, 8'd42, 1'b0, 8'd42, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp release w_in_ready", 32'(w_in_ready), 32'd1);
        @(posedge clk); #1;
        check_both_out("bp next", 1'b1, 2'd0, 8'd43, 1'b0, 8'd43, 1'b0);
        @(negedge clk);
        drive(1'b0, RD, 2'd0, 8'd0);
        @(posedge clk); #1;
        check("bp drained w_valid", 32'(w_out_valid), 32'd0);

        // Mid-stream reset while a result is stalled; reset beats the handshake.
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b1, LD, 2'd1, 8'd99);
        @(posedge clk); #1;
        check_both_out("mr load", 1'b1, 2'd1, 8'd99, 1'b0, 8'd99, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, ADD, 2'd1, 8'd1);
        @(posedge clk); #1;
        check_both_out("mr reset", 1'b0, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, RD, 2'(c), 8'd0);
            @(posedge clk); #1;
            // ch3 stays out of range on the 3-channel instance.
            check_both_out($sformatf("mr rd%0d", c), 1'b1, 2'(c), 8'd0, (c == 3), 8'd0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, RD, 2'd0, 8'd0);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
